jam_cost_server: RTL and testbench
==================================

// Module: jam_cost_server
// PURPOSE
//  Responder side of the job-assignment (JAM) cost interface. Holds the 8x8 worker/job cost table.
//  Serves Cost for every (W,J) address the solver drives. Captures the solver's MatchCount/MinCost
//  when it raises Valid.
//  Sits between the stimulus loader (streams the table in) and the JAM solver core (issues lookups).
// PARAMETERS
//  N       8    workers = jobs; table has N*N entries; W/J width = $clog2(N)
//  COST_W  7    width of one cost entry
//  MINC_W  10   width of MinCost (holds N*(2^COST_W-1) = 1016)
//  MC_W    4    width of MatchCount
//  RC_W    16   width of lookup counter
// PORTS
//  clk         in   1       rising-edge clock
//  reset       in   1       asynchronous, active-high
//  ld_valid    in   1       table load beat valid
//  ld_data     in   COST_W  cost entry, row-major: W outer, J inner
//  ld_ready    out  1       table load beat accepted when ld_valid&&ld_ready
//  serve_en    out  1       1 = table complete; solver may run
//  W           in   3       worker index from solver
//  J           in   3       job index from solver
//  Cost        out  COST_W  table[W][J], registered
//  Valid       in   1       solver result strobe
//  MatchCount  in   MC_W    solver result: number of optimal assignments
//  MinCost     in   MINC_W  solver result: minimum total cost
//  restart     in   1       DONE -> SERVE, table retained
//  res_valid   out  1       one-cycle pulse: result captured
//  res_match   out  MC_W    captured MatchCount
//  res_min     out  MINC_W  captured MinCost
//  req_cnt     out  RC_W    SERVE-cycle lookup count, saturating
//  proto_err   out  1       sticky protocol violation flag
// BEHAVIOUR
//  Reset values: state=LOAD, load addr=0, ld_ready=0, serve_en=0, Cost=0, res_valid=0,
//  res_match=0, res_min=0, req_cnt=0, proto_err=0. Table RAM contents are not reset.
//  FSM: LOAD -> SERVE -> DONE; DONE --restart--> SERVE; no other exits except reset.
//  LOAD:
//   - ld_ready=1 (combinational from state).
//   - Each accepted beat writes table[addr] and increments addr (6 bits).
//   - The 64th accept (addr==63) moves to SERVE next cycle; addr wraps to 0.
//   - ld_valid low stalls; no timeout.
//  SERVE:
//   - serve_en=1.
//   - Every cycle: Cost <= table[{W,J}]. Latency is exactly 1 clk; W/J changing every cycle is legal.
//   - req_cnt += 1 per SERVE cycle; saturates at 2^RC_W-1.
//   - Valid=1: res_match <= MatchCount, res_min <= MinCost, res_valid pulses 1 cycle, next state DONE.
//     If MatchCount==0 at Valid, proto_err is also set.
//  DONE:
//   - serve_en=0; Cost holds its last value; Valid is ignored.
//   - restart=1: clears req_cnt and goes to SERVE; res_* hold until the next capture.
//  Illegal events (set proto_err, otherwise ignored):
//   - Valid in LOAD.
//   - ld_valid in SERVE or DONE.
//  restart outside DONE: ignored; proto_err not set.
//  Reset mid-LOAD: addr returns to 0; the whole table must be reloaded.
//  Reset mid-SERVE: result is lost; state returns to LOAD.
//  Valid and the 64th load beat in the same cycle: the beat is accepted, Valid is flagged
//  as an error, and no capture occurs.
//  Widths: all compares unsigned; no arithmetic on cost data inside this block.
// STRUCTURE
//  jam_pkg (shared with solver):
//   - N, COST_W, MINC_W, MC_W.
//   - state enum {LOAD, SERVE, DONE}.
//   - address concat helper {W,J}.
//  Sub-module jam_cost_ram:
//   - N*N x COST_W, one write port, one synchronous read port.
//   - Read-during-write is don't-care: never occurs, writes only in LOAD.
//  Top holds the FSM, load address counter, result capture, req_cnt and proto_err.
// TESTING
//  1. Reset, stream 64 beats with data=(W*8+J)&0x7F and no gaps:
//     ld_ready low on the cycle after beat 64; serve_en=1.
//  2. SERVE, drive W=3,J=5, then W=7,J=7 on consecutive cycles:
//     Cost=29, then 63, each one clk later.
//  3. Toggle ld_valid 1/0 during load: exactly 64 accepts are required before serve_en;
//     Cost matches the loaded table.
//  4. Valid with MatchCount=2, MinCost=0x0F3 after 100 SERVE cycles:
//     res_valid is a 1-cycle pulse; res_match=2, res_min=243, req_cnt=100; state DONE.
//  5. Valid in LOAD, and Valid with MatchCount=0: proto_err=1 and stays 1 until reset.
//  6. Assert reset after beat 30, then reload 64 beats of 0x7F:
//     every (W,J) returns 127. Then restart from DONE: req_cnt=0 and res_* are retained.

Source files
------------

// File: rtl/jam_pkg.sv
// jam_pkg: shared constants, state enum and address helper for the JAM cost interface
package jam_pkg;
  localparam int N      = 8;
  localparam int COST_W = 7;
  localparam int MINC_W = 10;
  localparam int MC_W   = 4;
  localparam int RC_W   = 16;
  localparam int IDX_W  = $clog2(N);
  localparam int ADDR_W = 2 * IDX_W;

  typedef enum logic [1:0] {LOAD, SERVE, DONE} state_t;

  // Row-major table address: worker is the outer index, job the inner one.
  function automatic logic [ADDR_W-1:0] addr_of(input logic [IDX_W-1:0] w, input logic [IDX_W-1:0] j);
    return {w, j};
  endfunction
endpackage

// File: rtl/jam_cost_ram.sv
// jam_cost_ram: N*N cost table with one write port and a registered, enabled read port
module jam_cost_ram
  import jam_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [COST_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [COST_W-1:0] rdata
);
  logic [COST_W-1:0] mem [N*N];

  // Table storage is deliberately left unreset; a full reload always follows reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read register only updates while serving, so the last cost holds otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/jam_cost_server.sv
// jam_cost_server: loads the cost table, serves lookups to the solver and captures its result
module jam_cost_server
  import jam_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_valid,
  input  logic [COST_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              serve_en,
  input  logic [IDX_W-1:0]  W,
  input  logic [IDX_W-1:0]  J,
  output logic [COST_W-1:0] Cost,
  input  logic              Valid,
  input  logic [MC_W-1:0]   MatchCount,
  input  logic [MINC_W-1:0] MinCost,
  input  logic              restart,
  output logic              res_valid,
  output logic [MC_W-1:0]   res_match,
  output logic [MINC_W-1:0] res_min,
  output logic [RC_W-1:0]   req_cnt,
  output logic              proto_err
);
  state_t state, state_nx;
  logic [ADDR_W-1:0] addr;
  logic accept, last_beat, capture, do_restart, illegal;

  assign ld_ready   = state == LOAD && !reset;
  assign serve_en   = state == SERVE;
  assign accept     = ld_valid && ld_ready;
  assign last_beat  = accept && addr == ADDR_W'(N*N-1);
  assign capture    = serve_en && Valid;
  assign do_restart = state == DONE && restart;
  assign illegal    = (Valid && state == LOAD) || (ld_valid && state != LOAD) || (capture && MatchCount == '0);

  // Next state: table complete, result captured, or restart from DONE.
  always_comb begin
    state_nx = state;
    state_nx = (state == LOAD && last_beat) ? SERVE :
               capture                      ? DONE  :
               do_restart                   ? SERVE : state;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= LOAD;
    else state <= state_nx;
  end

  // Load address advances per accepted beat and wraps to 0 after the last one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) addr <= '0;
    else if (accept) addr <= addr + 1'b1;
  end

  // Lookup counter: one per SERVE cycle, saturating, cleared by restart.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) req_cnt <= '0;
    else if (do_restart) req_cnt <= '0;
    else if (serve_en && req_cnt != '1) req_cnt <= req_cnt + 1'b1;
  end

  // Result capture with a single-cycle strobe; captured values hold until the next capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_valid <= 1'b0;
      res_match <= '0;
      res_min   <= '0;
    end else begin
      res_valid <= capture;
      if (capture) begin
        res_match <= MatchCount;
        res_min   <= MinCost;
      end
    end
  end

  // Sticky protocol error flag, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) proto_err <= 1'b0;
    else if (illegal) proto_err <= 1'b1;
  end

  jam_cost_ram u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (accept),
    .waddr (addr),
    .wdata (ld_data),
    .re    (serve_en),
    .raddr (addr_of(W, J)),
    .rdata (Cost)
  );
endmodule

// File: tb/tb_jam_cost_server.sv
// tb_jam_cost_server: randomized stimulus against a behavioural model of the cost server
module tb_jam_cost_server;
  import jam_pkg::*;

  logic clk = 0, reset = 1;
  logic ld_valid = 0, Valid = 0, restart = 0;
  logic [COST_W-1:0] ld_data = '0;
  logic [IDX_W-1:0] W = '0, J = '0;
  logic [MC_W-1:0] MatchCount = '0;
  logic [MINC_W-1:0] MinCost = '0;
  logic ld_ready, serve_en, res_valid, proto_err;
  logic [COST_W-1:0] Cost;
  logic [MC_W-1:0] res_match;
  logic [MINC_W-1:0] res_min;
  logic [RC_W-1:0] req_cnt;

  int checks = 0, errors = 0;

  jam_cost_server dut (
    .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .serve_en(serve_en), .W(W), .J(J), .Cost(Cost), .Valid(Valid), .MatchCount(MatchCount),
    .MinCost(MinCost), .restart(restart), .res_valid(res_valid), .res_match(res_match),
    .res_min(res_min), .req_cnt(req_cnt), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  // Behavioural model: phase 0 = loading, 1 = serving, 2 = finished.
  int m_phase = 0, m_beats = 0, m_req = 0, m_cost = 0, m_match = 0, m_min = 0;
  bit m_rv = 0, m_err = 0;
  int m_tab [64];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase = 0; m_beats = 0; m_req = 0; m_cost = 0; m_match = 0; m_min = 0; m_rv = 0; m_err = 0;
    end else begin
      m_rv = 0;
      if (m_phase == 0) begin
        if (Valid) m_err = 1;
        if (ld_valid) begin
          m_tab[m_beats] = int'(ld_data);
          m_beats++;
          if (m_beats == 64) begin m_beats = 0; m_phase = 1; end
        end
      end else if (m_phase == 1) begin
        if (ld_valid) m_err = 1;
        m_cost = m_tab[int'(W) * 8 + int'(J)];
        if (m_req < 65535) m_req++;
        if (Valid) begin
          m_match = int'(MatchCount); m_min = int'(MinCost); m_rv = 1; m_phase = 2;
          if (MatchCount == 0) m_err = 1;
        end
      end else begin
        if (ld_valid) m_err = 1;
        if (restart) begin m_req = 0; m_phase = 1; end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every cycle, after the edge has settled.
  always @(posedge clk) begin
    #1;
    chk("ld_ready", 32'(ld_ready), 32'(m_phase == 0 && !reset));
    chk("serve_en", 32'(serve_en), 32'(m_phase == 1));
    chk("Cost", 32'(Cost), 32'(m_cost));
    chk("res_valid", 32'(res_valid), 32'(m_rv));
    chk("res_match", 32'(res_match), 32'(m_match));
    chk("res_min", 32'(res_min), 32'(m_min));
    chk("req_cnt", 32'(req_cnt), 32'(m_req));
    chk("proto_err", 32'(proto_err), 32'(m_err));
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic rnd_wj();
    W = IDX_W'($urandom); J = IDX_W'($urandom);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    step(); step();
    chk("rst_ld_ready", 32'(ld_ready), 0);
    chk("rst_Cost", 32'(Cost), 0);
    chk("rst_req_cnt", 32'(req_cnt), 0);
    chk("rst_proto_err", 32'(proto_err), 0);
    reset = 0;
    step();
    // Test 1: gapless load with data = W*8+J.
    for (int i = 0; i < 64; i++) begin
      ld_valid = 1; ld_data = COST_W'(i & 8'h7F);
      step();
    end
    ld_valid = 0;
    chk("t1_ld_ready_low", 32'(ld_ready), 0);
    chk("t1_serve_en", 32'(serve_en), 1);
    // Test 2: one-cycle lookup latency.
    W = 3; J = 5; step();
    chk("t2_cost_29", 32'(Cost), 29);
    W = 7; J = 7; step();
    chk("t2_cost_63", 32'(Cost), 63);
    for (int i = 2; i < 99; i++) begin
      rnd_wj(); restart = 1'($urandom);
      step();
    end
    restart = 0;
    // Test 4: capture on the 100th SERVE cycle.
    Valid = 1; MatchCount = 2; MinCost = 10'h0F3; rnd_wj();
    step();
    Valid = 0;
    chk("t4_res_valid", 32'(res_valid), 1);
    chk("t4_res_match", 32'(res_match), 2);
    chk("t4_res_min", 32'(res_min), 243);
    chk("t4_req_cnt", 32'(req_cnt), 100);
    chk("t4_serve_en_low", 32'(serve_en), 0);
    step();
    chk("t4_res_valid_pulse", 32'(res_valid), 0);
    for (int i = 0; i < 5; i++) begin
      rnd_wj(); Valid = 1'($urandom); MatchCount = MC_W'($urandom | 1); MinCost = MINC_W'($urandom);
      step();
    end
    Valid = 0;
    restart = 1; step(); restart = 0;
    chk("restart_req_cnt", 32'(req_cnt), 0);
    for (int i = 0; i < 20; i++) begin rnd_wj(); step(); end
    // Test 5b: MatchCount==0 at capture is an error.
    Valid = 1; MatchCount = 0; MinCost = 10'd17; step(); Valid = 0;
    chk("t5_err_mc0", 32'(proto_err), 1);
    ld_valid = 1; step(); ld_valid = 0; step();
    chk("t5_err_sticky", 32'(proto_err), 1);
    // Test 3 and 5a: gapped random load with Valid during LOAD and on the final beat.
    reset = 1; step();
    chk("reset_clears_err", 32'(proto_err), 0);
    reset = 0; step();
    begin
      int n = 0;
      while (n < 64) begin
        ld_valid = 1'($urandom); ld_data = COST_W'($urandom);
        Valid = (n == 10 && ld_valid) || (n == 63 && ld_valid);
        MatchCount = 5; MinCost = 10'd99;
        if (ld_valid) n++;
        step();
        if (n < 64) chk("t3_no_early_serve", 32'(serve_en), 0);
      end
    end
    ld_valid = 0; Valid = 0;
    chk("t3_serve_en", 32'(serve_en), 1);
    chk("t5_err_valid_load", 32'(proto_err), 1);
    chk("t5_no_capture", 32'(res_valid), 0);
    for (int i = 0; i < 200; i++) begin
      rnd_wj(); restart = 1'($urandom); step();
    end
    restart = 0;
    Valid = 1; MatchCount = 3; MinCost = MINC_W'($urandom); step(); Valid = 0;
    // Test 6: reset mid-load, reload with 0x7F everywhere.
    reset = 1; step(); reset = 0; step();
    for (int i = 0; i < 30; i++) begin ld_valid = 1; ld_data = COST_W'($urandom); step(); end
    ld_valid = 0;
    reset = 1; step(); reset = 0; step();
    chk("t6_reloading", 32'(serve_en), 0);
    for (int i = 0; i < 64; i++) begin ld_valid = 1; ld_data = 7'h7F; step(); end
    ld_valid = 0;
    for (int i = 0; i < 64; i++) begin
      W = IDX_W'(i / 8); J = IDX_W'(i % 8); step();
      chk("t6_cost_127", 32'(Cost), 127);
    end
    Valid = 1; MatchCount = 9; MinCost = 10'd500; step(); Valid = 0;
    step();
    restart = 1; step(); restart = 0;
    chk("t6_restart_req_cnt", 32'(req_cnt), 0);
    chk("t6_restart_serve", 32'(serve_en), 1);
    chk("t6_res_match_kept", 32'(res_match), 9);
    chk("t6_res_min_kept", 32'(res_min), 500);
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
